// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
// Bundle that connects the branch predictor to the fetch and decode stages.
//   Lookup : if_pc -> pred_hit / pred_taken / pred_target (combinational)
//   Update : upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken
//   Stats  : stat_branches, stat_mispredicts (only count when the predictor
//            is built with BP_STATS_EN; otherwise they are tied to 0)
// Modports:
//   master : pipeline side; drives the PC and the resolved branch outcomes
//   slave  : predictor side; returns the prediction and the statistics
// ---------------------------------------------------------------------------
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;

    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        input  pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        output pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Fetch-stage direction and target predictor. The table is a direct-mapped
// BTB with 2**IDX_W entries, each holding valid, tag, a 2-bit saturating
// counter and a 32-bit target. Lookup is combinational on the IF PC; the
// table is updated on the rising clock edge from the ID-stage resolution.
// A lookup in the same cycle as an update of that entry sees the old
// contents.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bp    : branch_predictor_if.slave (lookup, update and statistics)
//
// Parameters:
//   IDX_W    : index width, entries indexed by pc[IDX_W+1:2]
//   CTR_INIT : counter value written when an entry is allocated
//
// Build option:
//   BP_STATS_EN : when defined, stat_branches counts every resolved branch
//                 and stat_mispredicts counts direction mispredicts. When
//                 undefined both outputs are constant 0 and no counter flops
//                 exist.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic              validArr  [ENTRIES];
    logic [TAG_W-1:0]  tagArr    [ENTRIES];
    logic [1:0]        ctrArr    [ENTRIES];
    logic [31:0]       targetArr [ENTRIES];

    // Lookup path
    logic [IDX_W-1:0]  lookIdx;
    logic [TAG_W-1:0]  lookTag;
    logic              lookHit;

    assign lookIdx = bp.if_pc[IDX_W+1:2];
    assign lookTag = bp.if_pc[31:IDX_W+2];
    assign lookHit = validArr[lookIdx] && (tagArr[lookIdx] == lookTag);

    assign bp.pred_hit    = lookHit;
    assign bp.pred_taken  = lookHit && ctrArr[lookIdx][1];
    assign bp.pred_target = bp.pred_taken ? targetArr[lookIdx] : (bp.if_pc + 32'd4);

    // Update path
    logic [IDX_W-1:0]  updIdx;
    logic [TAG_W-1:0]  updTag;
    logic              updHit;

    assign updIdx = bp.upd_pc[IDX_W+1:2];
    assign updTag = bp.upd_pc[31:IDX_W+2];
    assign updHit = validArr[updIdx] && (tagArr[updIdx] == updTag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validArr[i]  <= 1'b0;
                tagArr[i]    <= '0;
                ctrArr[i]    <= 2'b01;
                targetArr[i] <= '0;
            end
        end else if (bp.upd_valid) begin
            if (updHit) begin
                if (bp.upd_taken) begin
                    if (ctrArr[updIdx] != 2'b11) begin
                        ctrArr[updIdx] <= ctrArr[updIdx] + 2'b01;
                    end
                    targetArr[updIdx] <= bp.upd_target;
                end else if (ctrArr[updIdx] != 2'b00) begin
                    ctrArr[updIdx] <= ctrArr[updIdx] - 2'b01;
                end
            end else if (bp.upd_taken) begin
                // Replacement only on a taken outcome, so a not-taken alias
                // never evicts a useful entry.
                validArr[updIdx]  <= 1'b1;
                tagArr[updIdx]    <= updTag;
                ctrArr[updIdx]    <= CTR_INIT;
                targetArr[updIdx] <= bp.upd_target;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] statBranches;
    logic [31:0] statMispredicts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            statBranches    <= '0;
            statMispredicts <= '0;
        end else if (bp.upd_valid) begin
            statBranches <= statBranches + 32'd1;
            if (bp.upd_pred_taken != bp.upd_taken) begin
                statMispredicts <= statMispredicts + 32'd1;
            end
        end
    end

    assign bp.stat_branches    = statBranches;
    assign bp.stat_mispredicts = statMispredicts;

    // Byte-offset bits do not participate in indexing or tagging.
    logic unusedBits;
    assign unusedBits = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};
`else
    assign bp.stat_branches    = 32'd0;
    assign bp.stat_mispredicts = 32'd0;

    logic unusedBits;
    assign unusedBits = ^{bp.if_pc[1:0], bp.upd_pc[1:0], bp.upd_pred_taken};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor (IDX_W=6, CTR_INIT=2'b10). Expected
// statistics follow BP_STATS_EN: counted when defined, 0 otherwise.
// ---------------------------------------------------------------------------
module tb_branch_predictor;
    logic clk;
    logic reset;

    branch_predictor_if bpIf ();

    branch_predictor #(.IDX_W(6), .CTR_INIT(2'b10)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bpIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int modelBr    = 0;
    int modelMis   = 0;

`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic expHit,
                          input logic expTaken, input logic [31:0] expTarget);
        bpIf.if_pc = pc;
        #1;
        check({tag, ".hit"},    {31'd0, bpIf.pred_hit},   {31'd0, expHit});
        check({tag, ".taken"},  {31'd0, bpIf.pred_taken}, {31'd0, expTaken});
        check({tag, ".target"}, bpIf.pred_target,         expTarget);
    endtask

    task automatic checkStats(input string tag);
        check({tag, ".branches"},    bpIf.stat_branches,    STATS ? 32'(modelBr)  : 32'd0);
        check({tag, ".mispredicts"}, bpIf.stat_mispredicts, STATS ? 32'(modelMis) : 32'd0);
    endtask

    task automatic doUpdate(input logic [31:0] pc, input logic taken,
                            input logic [31:0] target, input logic predTaken);
        @(negedge clk);
        bpIf.upd_valid      = 1'b1;
        bpIf.upd_pc         = pc;
        bpIf.upd_taken      = taken;
        bpIf.upd_target     = target;
        bpIf.upd_pred_taken = predTaken;
        @(posedge clk);
        #1;
        bpIf.upd_valid = 1'b0;
        modelBr++;
        if (predTaken != taken) modelMis++;
    endtask

    initial begin
        reset               = 1'b0;
        bpIf.if_pc          = 32'h0000_3000;
        bpIf.upd_valid      = 1'b0;
        bpIf.upd_pc         = 32'd0;
        bpIf.upd_taken      = 1'b0;
        bpIf.upd_target     = 32'd0;
        bpIf.upd_pred_taken = 1'b0;

        #12;
        lookup("in_reset", 32'h0000_3000, 1'b0, 1'b0, 32'h0000_3004);
        checkStats("in_reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        lookup("post_reset", 32'h0000_3000, 1'b0, 1'b0, 32'h0000_3004);

        // Allocate, then saturate at 11 with target refresh
        doUpdate(32'h0000_3010, 1'b1, 32'h0000_3100, 1'b0);
        lookup("alloc", 32'h0000_3010, 1'b1, 1'b1, 32'h0000_3100);
        doUpdate(32'h0000_3010, 1'b1, 32'h0000_3100, 1'b1);
        doUpdate(32'h0000_3010, 1'b1, 32'h0000_3200, 1'b1);
        lookup("sat_hi", 32'h0000_3010, 1'b1, 1'b1, 32'h0000_3200);

        // Hysteresis: 11 -> 10 still taken, -> 01 not taken
        doUpdate(32'h0000_3010, 1'b0, 32'h0000_9990, 1'b1);
        lookup("nt1", 32'h0000_3010, 1'b1, 1'b1, 32'h0000_3200);
        doUpdate(32'h0000_3010, 1'b0, 32'h0000_9990, 1'b1);
        lookup("nt2", 32'h0000_3010, 1'b1, 1'b0, 32'h0000_3014);

        // Floor at 00: three more not-taken, then two taken needed to predict taken
        doUpdate(32'h0000_3010, 1'b0, 32'h0, 1'b0);
        doUpdate(32'h0000_3010, 1'b0, 32'h0, 1'b0);
        doUpdate(32'h0000_3010, 1'b0, 32'h0, 1'b0);
        lookup("sat_lo", 32'h0000_3010, 1'b1, 1'b0, 32'h0000_3014);
        doUpdate(32'h0000_3010, 1'b1, 32'h0000_3300, 1'b0);
        lookup("lo_plus1", 32'h0000_3010, 1'b1, 1'b0, 32'h0000_3014);
        doUpdate(32'h0000_3010, 1'b1, 32'h0000_3300, 1'b0);
        lookup("lo_plus2", 32'h0000_3010, 1'b1, 1'b1, 32'h0000_3300);

        // Not-taken miss allocates nothing
        doUpdate(32'h0000_4000, 1'b0, 32'h0000_4444, 1'b0);
        lookup("nt_miss", 32'h0000_4000, 1'b0, 1'b0, 32'h0000_4004);

        // Alias at index 4 replaces on taken
        doUpdate(32'h0000_3110, 1'b1, 32'h0000_3500, 1'b0);
        lookup("alias_old", 32'h0000_3010, 1'b0, 1'b0, 32'h0000_3014);
        lookup("alias_new", 32'h0000_3110, 1'b1, 1'b1, 32'h0000_3500);
        lookup("low_bits", 32'h0000_3113, 1'b1, 1'b1, 32'h0000_3500);
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // Same-cycle lookup and update: old contents before the edge
        @(negedge clk);
        bpIf.if_pc          = 32'h0000_3020;
        bpIf.upd_valid      = 1'b1;
        bpIf.upd_pc         = 32'h0000_3020;
        bpIf.upd_taken      = 1'b1;
        bpIf.upd_target     = 32'h0000_3600;
        bpIf.upd_pred_taken = 1'b0;
        #1;
        check("same_cycle.before", {31'd0, bpIf.pred_hit}, 32'd0);
        @(posedge clk);
        #1;
        bpIf.upd_valid = 1'b0;
        modelBr++;
        modelMis++;
        lookup("same_cycle.after", 32'h0000_3020, 1'b1, 1'b1, 32'h0000_3600);

        // upd_valid low: a not-taken on the bus must be ignored
        @(negedge clk);
        bpIf.upd_pc    = 32'h0000_3020;
        bpIf.upd_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        lookup("no_valid", 32'h0000_3020, 1'b1, 1'b1, 32'h0000_3600);
        checkStats("pre_reset");

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        modelBr  = 0;
        modelMis = 0;
        lookup("async_reset", 32'h0000_3020, 1'b0, 1'b0, 32'h0000_3024);
        checkStats("async_reset");

        // First edge after release performs a normal update
        bpIf.upd_valid      = 1'b1;
        bpIf.upd_pc         = 32'h0000_3040;
        bpIf.upd_taken      = 1'b1;
        bpIf.upd_target     = 32'h0000_3700;
        bpIf.upd_pred_taken = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        bpIf.upd_valid = 1'b0;
        modelBr++;
        lookup("release_upd", 32'h0000_3040, 1'b1, 1'b1, 32'h0000_3700);

        doUpdate(32'h0000_3040, 1'b1, 32'h0000_3700, 1'b0);
        doUpdate(32'h0000_3050, 1'b0, 32'h0000_3800, 1'b1);
        doUpdate(32'h0000_3040, 1'b1, 32'h0000_3700, 1'b1);
        doUpdate(32'h0000_3060, 1'b0, 32'h0000_3900, 1'b0);
        check("five.model_br", 32'(modelBr), 32'd5);
        check("five.model_mis", 32'(modelMis), 32'd2);
        checkStats("five_updates");
        lookup("nt_miss2", 32'h0000_3050, 1'b0, 1'b0, 32'h0000_3054);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage direction and target predictor.
- It consumes the branch outcomes that the ID-stage comparator resolves, and feeds fetch a predicted next PC.
- Direct-mapped branch target buffer (BTB) of 2-bit saturating counters plus targets.
- Lookup is combinational on the IF PC. Update is sequential, driven by the ID-stage resolution.

Parameters:
- IDX_W, 6, index width; table holds 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_pc  input  32  PC in IF; word-aligned.
- pred_hit  output  1  valid entry and tag match for if_pc.
- pred_taken  output  1  pred_hit && ctr[1].
- pred_target  output  32  stored target when pred_taken, else if_pc+4.
- upd_valid  input  1  ID resolved a conditional branch this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  resolved direction (comparator isBranch).
- upd_target  input  32  computed branch target.
- upd_pred_taken  input  1  prediction carried down with that branch (stats only).
- stat_branches  output  32  resolved-branch count (feature-gated).
- stat_mispredicts  output  32  direction-mispredict count (feature-gated).

Behaviour:
- Entry fields: valid, tag = pc[31:IDX_W+2], ctr[1:0], target[31:0].
- Reset (reset low, asynchronous):
  - all valid <= 0, all ctr <= 2'b01, all target <= 0, stat counters <= 0.
  - Outputs while in reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Lookup:
  - Purely combinational, zero latency; no state change.
  - pc[1:0] ignored.
  - pred_target wraps modulo 2**32 (0xFFFFFFFC -> 0x00000000).
- Update on posedge clk when upd_valid=1. Index i = upd_pc[IDX_W+1:2].
  - Hit (valid and tag match):
    - ctr saturating: taken -> min(ctr+1, 3); not-taken -> max(ctr-1, 0).
    - If taken, target <= upd_target.
  - Miss, taken: allocate/replace; valid<=1, tag<=upd_pc tag, ctr<=CTR_INIT, target<=upd_target.
  - Miss, not-taken: no table change.
- upd_valid=0: table unchanged; upd_* ignored.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass). The new value is visible the next cycle.
- Counter semantics:
  - 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
  - Prediction = ctr[1].
- Aliasing: a different tag at the same index is a miss. Replacement occurs only on a taken resolution.
- Reset deasserting mid-operation: the first rising edge after release performs a normal update if upd_valid=1.
- Table state is read via the lookup port only.
- Implementation: register arrays with asynchronous reset; no RAM inference requirement.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - stat_branches increments by 1 on every clock with upd_valid=1.
  - stat_mispredicts increments when upd_valid=1 and upd_pred_taken != upd_taken.
  - Both wrap at 2**32.
  - Both clear on reset.
- Undefined:
  - Ports stay present; both driven constant 0.
  - upd_pred_taken is unused.
  - No counter flops are synthesized.

Test Plan:
- Reset then lookup if_pc=0x00003000 -> pred_hit=0, pred_taken=0, pred_target=0x00003004.
- Taken allocate:
  - Stimulus: upd_valid=1, upd_pc=0x00003010, upd_taken=1, upd_target=0x00003100, one edge.
  - Response: lookup 0x00003010 gives pred_hit=1, pred_taken=1, pred_target=0x00003100 (ctr=10).
- Saturation and hysteresis on that entry:
  - Two further taken updates -> ctr=11.
  - One not-taken -> ctr=10, still pred_taken=1.
  - Second not-taken -> ctr=01, pred_taken=0, pred_target=0x00003014.
  - Three more not-taken -> ctr stays 00.
- Not-taken miss and alias (IDX_W=6):
  - Not-taken update to 0x00004000 -> lookup still pred_hit=0.
  - Taken update to 0x00003110 (same index as 0x00003010, different tag) -> 0x00003010 now misses, 0x00003110 hits.
- Same-cycle read/write: with if_pc=upd_pc=0x00003020 and a taken allocate on the same edge, pred_hit=0 before the edge and 1 after it.
- Async reset and stats (with BP_STATS_EN):
  - Run 5 updates, 2 with upd_pred_taken != upd_taken -> stat_branches=5, stat_mispredicts=2.
  - Pull reset low between clock edges -> pred_hit drops to 0 and stats read 0 immediately, without waiting for a clock.
  - Without the macro, both stats read 0 throughout.
